// File: rtl/templatized_alu_exec_if.sv
// rtl/templatized_alu_exec_if.sv - op/result handshake bundle for the ALU execute stage
interface templatized_alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_code;
  logic [2:0]       en;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_illegal;

  modport master (
    output in_valid, op_code, en, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, out_illegal
  );

  modport slave (
    input  in_valid, op_code, en, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, out_illegal
  );
endinterface

// File: rtl/templatized_alu_exec.sv
// rtl/templatized_alu_exec.sv - execute stage: 1-cycle arith/logic, bit-serial shift/rotate
module templatized_alu_exec #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  templatized_alu_exec_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [1:0]       sop_q, sop_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             out_illegal_q, out_illegal_d;

  logic [SW-1:0]    k;
  logic             legal;
  logic             lt, gt;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign k               = bus.operand_b[SW-1:0];
  assign bus.in_ready    = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.out_illegal = out_illegal_q;

  // en must be exactly the one-hot group the op_code belongs to
  always_comb begin
    legal = 1'b0;
    case (bus.op_code)
      4'd0, 4'd1, 4'd2, 4'd3: legal = (bus.en == 3'b100);
      4'd4:                   legal = (bus.en == 3'b010);
      4'd5, 4'd6, 4'd7, 4'd8: legal = (bus.en == 3'b001);
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    if (SIGNED_CMP) begin
      lt = $signed(bus.operand_a) < $signed(bus.operand_b);
      gt = $signed(bus.operand_a) > $signed(bus.operand_b);
    end else begin
      lt = bus.operand_a < bus.operand_b;
      gt = bus.operand_a > bus.operand_b;
    end
  end

  // sop: 0 SLL, 1 SAR, 2 ROTL, 3 ROTR
  always_comb begin
    case (sop_q)
      2'd0:    shifted = {work_q[WIDTH-2:0], 1'b0};
      2'd1:    shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      2'd2:    shifted = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      default: shifted = {work_q[0], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sop_d         = sop_q;
    work_d        = work_q;
    result_d      = result_q;
    out_valid_d   = out_valid_q;
    out_illegal_d = out_illegal_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == SHIFT) begin
      work_d = shifted;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == 1) begin
        result_d      = shifted;
        out_valid_d   = 1'b1;
        out_illegal_d = 1'b0;
        state_d       = IDLE;
      end
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_illegal_d = !legal;
      if (!legal) begin
        result_d = '0;
      end else begin
        case (bus.op_code)
          4'd0:    result_d = bus.operand_a + bus.operand_b;
          4'd1:    result_d = bus.operand_a - bus.operand_b;
          4'd2:    result_d = {{(WIDTH-1){1'b0}}, lt};
          4'd3:    result_d = {{(WIDTH-1){1'b0}}, gt};
          4'd4:    result_d = bus.operand_a ^ bus.operand_b;
          default: begin
            if (k == '0) begin
              result_d = bus.operand_a;
            end else begin
              // result waits for the last SHIFT edge
              out_valid_d = 1'b0;
              work_d      = bus.operand_a;
              cnt_d       = k;
              sop_d       = bus.op_code[1:0] - 2'd1;
              state_d     = SHIFT;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sop_q         <= '0;
      work_q        <= '0;
      result_q      <= '0;
      out_valid_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sop_q         <= sop_d;
      work_q        <= work_d;
      result_q      <= result_d;
      out_valid_q   <= out_valid_d;
      out_illegal_q <= out_illegal_d;
    end
  end
endmodule

// File: tb/tb_templatized_alu_exec.sv
// tb/tb_templatized_alu_exec.sv - directed and randomized checks of the ALU execute stage
module tb_templatized_alu_exec;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [7:0] r;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];

  templatized_alu_exec_if #(.WIDTH(8)) bus ();
  templatized_alu_exec_if #(.WIDTH(8)) bus_u ();

  templatized_alu_exec #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  templatized_alu_exec #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .bus(bus_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [2:0] e,
                                input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic ill);
    int grp;
    int k;
    int ua;
    int ub;
    grp = (op <= 3) ? 4 : (op == 4) ? 2 : (op <= 8) ? 1 : 0;
    ill = !(grp != 0 && int'(e) == grp);
    r   = 8'h00;
    if (ill) return;
    k  = int'(b) % 8;
    ua = int'(a);
    ub = int'(b);
    case (op)
      4'd0:    r = 8'((ua + ub) % 256);
      4'd1:    r = 8'((ua - ub + 256) % 256);
      4'd2:    r = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
      4'd3:    r = ($signed(a) > $signed(b)) ? 8'h01 : 8'h00;
      4'd4:    r = a ^ b;
      4'd5:    r = 8'((ua << k) % 256);
      4'd6:    r = 8'($signed(a) >>> k);
      4'd7:    r = 8'(((ua << k) | (ua >> (8 - k))) % 256);
      default: r = 8'(((ua >> k) | (ua << (8 - k))) % 256);
    endcase
  endfunction

  function automatic int shift_edges(input logic [3:0] op, input logic [2:0] e, input logic [7:0] b);
    logic [7:0] r;
    logic       ill;
    model(op, e, 8'h00, b, r, ill);
    return (!ill && op >= 5 && op <= 8) ? int'(b) % 8 : 0;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] e,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_r, input logic exp_ill, input int exp_edges,
                        output int lows);
    int n;
    lows = 0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.op_code   = op;
    bus.en        = e;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      if (!bus.in_ready) lows++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_edges));
    check({tag, "_res"}, 32'(bus.result), 32'(exp_r));
    check({tag, "_ill"}, 32'(bus.out_illegal), 32'(exp_ill));
  endtask

  initial begin
    int         lows;
    int         highs;
    int         sent;
    int         got;
    bit         fire;
    logic [3:0] op;
    logic [2:0] e;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       ex;
    exp_t       ob;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0; bus.op_code = '0; bus.en = '0;
    bus.operand_a = '0; bus.operand_b = '0; bus.out_ready = 1'b0;
    bus_u.in_valid = 1'b0; bus_u.op_code = '0; bus_u.en = '0;
    bus_u.operand_a = '0; bus_u.operand_b = '0; bus_u.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_illegal", 32'(bus.out_illegal), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    run_op("add", 4'd0, 3'b100, 8'hF0, 8'h20, 8'h10, 1'b0, 0, lows);
    run_op("sub", 4'd1, 3'b100, 8'h00, 8'h01, 8'hFF, 1'b0, 0, lows);
    run_op("lt_s", 4'd2, 3'b100, 8'h80, 8'h01, 8'h01, 1'b0, 0, lows);
    run_op("gt_s", 4'd3, 3'b100, 8'h80, 8'h01, 8'h00, 1'b0, 0, lows);
    run_op("sar", 4'd6, 3'b001, 8'h80, 8'h03, 8'hF0, 1'b0, 3, lows);
    check("sar_ready_low", 32'(lows), 32'd3);
    run_op("sll", 4'd5, 3'b001, 8'h81, 8'h0B, 8'h08, 1'b0, 3, lows);
    run_op("rotr", 4'd8, 3'b001, 8'h01, 8'h09, 8'h80, 1'b0, 1, lows);
    run_op("rotl_k0", 4'd7, 3'b001, 8'h5C, 8'h08, 8'h5C, 1'b0, 0, lows);
    run_op("rotl7", 4'd7, 3'b001, 8'h03, 8'h07, 8'h81, 1'b0, 7, lows);

    @(posedge clk); #1;
    bus_u.in_valid = 1'b1; bus_u.op_code = 4'd2; bus_u.en = 3'b100;
    bus_u.operand_a = 8'h80; bus_u.operand_b = 8'h01;
    @(posedge clk); #1;
    bus_u.in_valid = 1'b0;
    check("lt_u_valid", 32'(bus_u.out_valid), 32'd1);
    check("lt_u_res", 32'(bus_u.result), 32'd0);

    // backpressure: ADD held, then XOR accepted on the draining cycle
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op_code = 4'd0; bus.en = 3'b100;
    bus.operand_a = 8'hF0; bus.operand_b = 8'h20; bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_res", 32'(bus.result), 32'h10);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1; bus.op_code = 4'd4; bus.en = 3'b010;
    bus.operand_a = 8'h5A; bus.operand_b = 8'hFF; bus.out_ready = 1'b1;
    #1;
    check("bp_xor_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_xor_valid", 32'(bus.out_valid), 32'd1);
    check("bp_xor_res", 32'(bus.result), 32'hA5);
    check("bp_xor_ill", 32'(bus.out_illegal), 32'd0);

    run_op("ill_opA", 4'hA, 3'b000, 8'h12, 8'h34, 8'h00, 1'b1, 0, lows);
    run_op("ill_add", 4'd0, 3'b001, 8'h12, 8'h34, 8'h00, 1'b1, 0, lows);
    run_op("ill_xor", 4'd4, 3'b110, 8'h12, 8'h34, 8'h00, 1'b1, 0, lows);
    run_op("ill_sar", 4'd6, 3'b011, 8'h80, 8'h03, 8'h00, 1'b1, 0, lows);
    run_op("legal_after", 4'd0, 3'b100, 8'h01, 8'h02, 8'h03, 1'b0, 0, lows);

    // reset in the third SHIFT cycle of SLL k=7
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op_code = 4'd5; bus.en = 3'b001;
    bus.operand_a = 8'hFF; bus.operand_b = 8'h07; bus.out_ready = 1'b1;
    @(negedge clk);
    check("rm_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rm_in_ready_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("rm_valid_rst", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) highs++;
      @(posedge clk); #1;
    end
    check("rm_no_output", 32'(highs), 32'd0);
    check("rm_in_ready", 32'(bus.in_ready), 32'd1);
    check("rm_result", 32'(bus.result), 32'd0);
    run_op("rm_add", 4'd0, 3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 0, lows);

    // randomized traffic against the queue-based reference
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sent = 0;
    got  = 0;
    fire = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 80000 && got < 3000; cyc++) begin
      @(posedge clk); #1;
      if (fire) bus.in_valid = 1'b0;
      fire = 1'b0;
      if (!bus.in_valid && sent < 3000 && $urandom_range(0, 3) != 0) begin
        op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        model(op, 3'b000, 8'h00, 8'h00, ex.r, ex.ill);
        e = (op <= 3) ? 3'b100 : (op == 4) ? 3'b010 : 3'b001;
        if ($urandom_range(0, 4) == 0) e = 3'($urandom_range(0, 7));
        a = 8'($urandom);
        b = 8'($urandom);
        bus.in_valid = 1'b1; bus.op_code = op; bus.en = e;
        bus.operand_a = a; bus.operand_b = b;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious", 32'd1, 32'd0);
        end else begin
          ex = exp_q.pop_front();
          ob.r = bus.result;
          ob.ill = bus.out_illegal;
          check("rnd_res", 32'(ob.r), 32'(ex.r));
          check("rnd_ill", 32'(ob.ill), 32'(ex.ill));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        model(bus.op_code, bus.en, bus.operand_a, bus.operand_b, ex.r, ex.ill);
        if (shift_edges(bus.op_code, bus.en, bus.operand_b) > 0) begin
          check("rnd_shift_start", 32'(exp_q.size()), 32'(exp_q.size()));
        end
        exp_q.push_back(ex);
        sent++;
        fire = 1'b1;
      end
    end
    check("rnd_sent", 32'(sent), 32'd3000);
    check("rnd_got", 32'(got), 32'd3000);
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
